instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Writer side of the instruction memory. Receives a program as a little-endian
//  byte stream (valid/ready) and packs every 4 bytes into one 32-bit word.
//  Issues one word write per packed word into the instruction memory array.
//  Holds the core in reset until the load completes, replacing the fixed
//  reset-time program image.
// PARAMETERS
//  DEPTH_BYTES  128    instruction memory size in bytes; max load = DEPTH_BYTES/4 words
//  BASE_ADDR    32'h0  byte address of the first word written
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst_n        in   1   asynchronous active-low reset
//  i_start        in   1   1-cycle pulse: begin a load (sampled only in IDLE/DONE/ERR)
//  i_len_words    in   16  number of words to load, sampled with i_start
//  i_byte_valid   in   1   i_byte holds a valid program byte
//  i_byte         in   8   program byte, lowest address first
//  o_byte_ready   out  1   loader accepts i_byte this cycle
//  o_wr_en        out  1   1-cycle word write strobe to instruction memory
//  o_wr_adr       out  32  byte address of the write (word aligned)
//  o_wr_data      out  32  write data: {b3,b2,b1,b0}, where b0 is the first byte
//  o_busy         out  1   load in progress (RECV or WRITE)
//  o_done         out  1   load complete; held until the next accepted i_start
//  o_err          out  1   length overflow; held until the next accepted i_start
//  o_cpu_rst_n    out  1   core reset, active-low; 1 only in DONE
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE; all counters 0; all outputs 0.
//   o_wr_adr resets to BASE_ADDR. o_cpu_rst_n=0.
//  Byte transfer: a byte moves on a rising edge with i_byte_valid & o_byte_ready.
//   o_byte_ready depends only on state (RECV), never on i_byte_valid.
//  States:
//   IDLE: ready=0. On i_start:
//    len==0               -> DONE
//    len>DEPTH_BYTES/4    -> ERR
//    otherwise            -> RECV; word_cnt=0, byte_cnt=0, len latched.
//   RECV: ready=1, busy=1. Each transfer places i_byte in lane byte_cnt
//    (lane 0 = bits[7:0]) and increments byte_cnt (2-bit, wraps).
//    The 4th byte (byte_cnt==3) -> WRITE.
//   WRITE: ready=0, busy=1, o_wr_en=1 for exactly 1 cycle.
//    o_wr_adr = BASE_ADDR + 4*word_cnt; o_wr_data = packed word.
//    Next: word_cnt+1==len -> DONE; else word_cnt++ and -> RECV.
//   DONE: done=1, cpu_rst_n=1. i_start is handled as in IDLE and clears done.
//   ERR: err=1, cpu_rst_n=0. i_start is handled as in IDLE and clears err.
//  i_start during RECV/WRITE is ignored.
//  Bytes presented outside RECV are not consumed.
//  Address arithmetic is 32-bit unsigned; word_cnt is 16-bit.
//   Overflow cannot occur because len is bounded.
//  o_wr_adr/o_wr_data are registered and stable while o_wr_en=1.
//   Outside WRITE they hold their last values.
//  Throughput: minimum 5 cycles per word (4 RECV + 1 WRITE).
//   DONE is entered the cycle after the last WRITE.
//  Mid-load reset: the partial word is discarded, no o_wr_en is issued,
//   and all outputs return to reset values.
// TESTING
//  1. len=2; bytes 93 02 40 00 83 a3 42 00 back-to-back ->
//     wr@0x0=0x00400293, wr@0x4=0x0042a383; done=1, cpu_rst_n=1 next cycle.
//  2. Same stream with random valid gaps -> identical writes; no byte lost or duplicated;
//     ready stays 1 through gaps.
//  3. len=0 -> DONE one cycle after start; o_wr_en never asserted.
//  4. len=33 with DEPTH_BYTES=128 -> err=1, cpu_rst_n=0, no writes;
//     then start with len=1 -> err clears and the load proceeds.
//  5. i_rst_n low after 3 bytes of word 1 -> all outputs at reset values, no write;
//     a restarted load writes 0x0 correctly.
//  6. i_start pulsed in RECV and in WRITE -> ignored; word_cnt, byte_cnt and len unchanged.

Source files
------------

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Writer side of the instruction memory. Takes a program as a little-endian
//   byte stream (valid/ready), packs every 4 bytes into a 32-bit word, and
//   issues one word write per packed word. The core is held in reset until
//   the whole program has been written.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_start           1-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   i_len_words       number of words to load, sampled with i_start
//   i_byte_valid      i_byte carries a program byte
//   i_byte            program byte, lowest address first
//   o_byte_ready      loader accepts i_byte this cycle (state-only decode)
//   o_wr_en           1-cycle word write strobe
//   o_wr_adr          word-aligned byte address of the write
//   o_wr_data         packed word {b3,b2,b1,b0}, b0 = first byte received
//   o_busy            load in progress (RECV or WRITE)
//   o_done            load complete, held until the next accepted i_start
//   o_err             requested length too large, held until next i_start
//   o_cpu_rst_n       core reset, released only in DONE
// ---------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int          DEPTH_BYTES = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_len_words,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_wr_en,
  output logic [31:0] o_wr_adr,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_rst_n
);

  localparam logic [31:0] MAX_WORDS = 32'(DEPTH_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] word_cnt;
  logic [15:0] len_q;
  logic [1:0]  byte_cnt;
  logic [23:0] byte_buf;   // lanes 0..2; lane 3 goes straight into o_wr_data

  logic idle_like;
  logic start_load;
  logic accept;
  logic last_word;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign accept     = (state == S_RECV) && i_byte_valid;
  assign last_word  = (word_cnt + 16'd1) == len_q;
  assign start_load = idle_like && i_start && (state_nxt == S_RECV);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          if (i_len_words == 16'd0)                 state_nxt = S_DONE;
          else if ({16'd0, i_len_words} > MAX_WORDS) state_nxt = S_ERR;
          else                                      state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (accept && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = last_word ? S_DONE : S_RECV;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: counters, byte packing, write address/data registers.
  // o_wr_adr/o_wr_data are loaded on the 4th byte so they are already stable
  // for the whole WRITE cycle and hold afterwards.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_cnt  <= '0;
      len_q     <= '0;
      byte_cnt  <= '0;
      byte_buf  <= '0;
      o_wr_adr  <= BASE_ADDR;
      o_wr_data <= '0;
    end else begin
      if (start_load) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        len_q    <= i_len_words;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: byte_buf[7:0]   <= i_byte;
          2'd1: byte_buf[15:8]  <= i_byte;
          2'd2: byte_buf[23:16] <= i_byte;
          default: begin
            o_wr_data <= {i_byte, byte_buf};
            o_wr_adr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
          end
        endcase
      end
      if ((state == S_WRITE) && !last_word) word_cnt <= word_cnt + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State-decoded outputs (all driven from the state register)
  // -------------------------------------------------------------------------
  assign o_byte_ready = (state == S_RECV);
  assign o_wr_en      = (state == S_WRITE);
  assign o_busy       = (state == S_RECV) || (state == S_WRITE);
  assign o_done       = (state == S_DONE);
  assign o_err        = (state == S_ERR);
  assign o_cpu_rst_n  = (state == S_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [15:0] i_len_words;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_wr_en;
  logic [31:0] o_wr_adr;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_cpu_rst_n;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_wr     = 0;
  logic [31:0] wq_adr[$];
  logic [31:0] wq_dat[$];

  instr_mem_loader #(.DEPTH_BYTES(128), .BASE_ADDR(32'h0)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_len_words  (i_len_words),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_adr     (o_wr_adr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_cpu_rst_n  (o_cpu_rst_n)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // o_wr_en lasts exactly one cycle, so one falling edge sees each write
  always @(negedge i_clk) begin
    if (o_wr_en) begin
      n_wr <= n_wr + 1;
      wq_adr.push_back(o_wr_adr);
      wq_dat.push_back(o_wr_data);
    end
  end

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic do_start(input logic [15:0] len);
    i_start     = 1'b1;
    i_len_words = len;
    @(negedge i_clk);
    i_start     = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the byte moved.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte_valid = 1'b1;
    i_byte       = b;
    while (!o_byte_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    n_checks++;
    if (!o_byte_ready) begin
      $display("FAIL send_byte_timeout: byte %h never accepted, ready=%b want 1", b, o_byte_ready);
      i_byte_valid = 1'b0;
    end else begin
      n_pass++;
      @(posedge i_clk);
      @(negedge i_clk);
      i_byte_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_len_words = '0;
    i_byte_valid = 1'b0; i_byte = '0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({o_byte_ready, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {o_byte_ready, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n});
    else n_pass++;
    n_checks++;
    if (o_wr_adr !== 32'h0 || o_wr_data !== 32'h0)
      $display("FAIL reset_adr_data: got %h/%h want 00000000/00000000", o_wr_adr, o_wr_data);
    else n_pass++;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_byte_ready !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b ready=%b want 0 0", o_busy, o_byte_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [8];
    int c0, w0;
    s = '{8'h93, 8'h02, 8'h40, 8'h00, 8'h83, 8'ha3, 8'h42, 8'h00};
    w0 = n_wr;
    do_start(16'd2);
    c0 = cyc;
    n_checks++;
    if (o_busy !== 1'b1 || o_cpu_rst_n !== 1'b0)
      $display("FAIL b2b_busy: busy=%b cpu_rst_n=%b want 1 0", o_busy, o_cpu_rst_n);
    else n_pass++;
    for (int i = 0; i < 4; i++) send_byte(s[i]);
    n_checks++;
    if (o_wr_en !== 1'b1 || o_wr_adr !== 32'h0 || o_wr_data !== 32'h00400293)
      $display("FAIL b2b_word0: en=%b adr=%h data=%h want 1 00000000 00400293",
               o_wr_en, o_wr_adr, o_wr_data);
    else n_pass++;
    for (int i = 4; i < 8; i++) send_byte(s[i]);
    n_checks++;
    if (o_wr_en !== 1'b1 || o_wr_adr !== 32'h4 || o_wr_data !== 32'h0042a383)
      $display("FAIL b2b_word1: en=%b adr=%h data=%h want 1 00000004 0042a383",
               o_wr_en, o_wr_adr, o_wr_data);
    else n_pass++;
    @(negedge i_clk);
    #1;
    n_checks++;
    if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1 || o_busy !== 1'b0 || o_wr_en !== 1'b0)
      $display("FAIL b2b_done: done=%b cpu_rst_n=%b busy=%b en=%b want 1 1 0 0",
               o_done, o_cpu_rst_n, o_busy, o_wr_en);
    else n_pass++;
    n_checks++;
    if (cyc - c0 !== 10)
      $display("FAIL b2b_cycles: got %0d want 10", cyc - c0);
    else n_pass++;
    n_checks++;
    if (n_wr - w0 !== 2)
      $display("FAIL b2b_nwrites: got %0d want 2", n_wr - w0);
    else n_pass++;
  endtask

  task automatic test_midload_reset();
    int w0;
    w0 = n_wr;
    do_start(16'd2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_byte_ready, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n} !== 6'b0 ||
        o_wr_adr !== 32'h0 || o_wr_data !== 32'h0)
      $display("FAIL midrst_outputs: flags=%b adr=%h data=%h want 000000 0 0",
               {o_byte_ready, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n}, o_wr_adr, o_wr_data);
    else n_pass++;
    i_byte_valid = 1'b1; i_byte = 8'h44;
    repeat (3) @(negedge i_clk);
    i_byte_valid = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    #1;
    n_checks++;
    if (n_wr !== w0 || o_busy !== 1'b0)
      $display("FAIL midrst_nowrite: writes=%0d busy=%b want %0d 0", n_wr, o_busy, w0);
    else n_pass++;
    do_start(16'd1);
    send_byte(8'h37); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    n_checks++;
    if (o_wr_en !== 1'b1 || o_wr_adr !== 32'h0 || o_wr_data !== 32'h01000137)
      $display("FAIL midrst_restart: en=%b adr=%h data=%h want 1 00000000 01000137",
               o_wr_en, o_wr_adr, o_wr_data);
    else n_pass++;
    @(negedge i_clk);
    n_checks++;
    if (o_done !== 1'b1)
      $display("FAIL midrst_done: got %b want 1", o_done);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [7:0] s [8];
    int g [8];
    int w0;
    s = '{8'h93, 8'h02, 8'h40, 8'h00, 8'h83, 8'ha3, 8'h42, 8'h00};
    g = '{2, 1, 3, 0, 1, 2, 0, 4};
    w0 = wq_adr.size();
    do_start(16'd2);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < g[i]; k++) begin
        @(negedge i_clk);
        if (i % 4 != 0) begin
          n_checks++;
          if (o_byte_ready !== 1'b1)
            $display("FAIL gap_ready: byte %0d gap %0d ready=%b want 1", i, k, o_byte_ready);
          else n_pass++;
        end
      end
      send_byte(s[i]);
    end
    @(negedge i_clk);
    #1;
    n_checks++;
    if (wq_adr.size() - w0 !== 2)
      $display("FAIL gap_nwrites: got %0d want 2", wq_adr.size() - w0);
    else begin
      n_pass++;
      n_checks++;
      if (wq_adr[w0] !== 32'h0 || wq_dat[w0] !== 32'h00400293 ||
          wq_adr[w0+1] !== 32'h4 || wq_dat[w0+1] !== 32'h0042a383)
        $display("FAIL gap_words: got %h=%h %h=%h want 0=00400293 4=0042a383",
                 wq_adr[w0], wq_dat[w0], wq_adr[w0+1], wq_dat[w0+1]);
      else n_pass++;
    end
    n_checks++;
    if (o_done !== 1'b1)
      $display("FAIL gap_done: got %b want 1", o_done);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    int w0;
    w0 = n_wr;
    do_start(16'd0);
    n_checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_cpu_rst_n !== 1'b1)
      $display("FAIL len0_done: done=%b busy=%b cpu_rst_n=%b want 1 0 1",
               o_done, o_busy, o_cpu_rst_n);
    else n_pass++;
    repeat (3) @(negedge i_clk);
    #1;
    n_checks++;
    if (n_wr !== w0)
      $display("FAIL len0_nowrite: writes=%0d want %0d", n_wr, w0);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int w0;
    w0 = n_wr;
    do_start(16'd33);
    n_checks++;
    if (o_err !== 1'b1 || o_cpu_rst_n !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL ovf_err: err=%b cpu_rst_n=%b done=%b busy=%b want 1 0 0 0",
               o_err, o_cpu_rst_n, o_done, o_busy);
    else n_pass++;
    i_byte_valid = 1'b1; i_byte = 8'hff;
    repeat (2) @(negedge i_clk);
    i_byte_valid = 1'b0;
    #1;
    n_checks++;
    if (n_wr !== w0 || o_err !== 1'b1 || o_byte_ready !== 1'b0)
      $display("FAIL ovf_hold: writes=%0d err=%b ready=%b want %0d 1 0",
               n_wr, o_err, o_byte_ready, w0);
    else n_pass++;
    do_start(16'd32);
    n_checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL max_len_accept: err=%b busy=%b want 0 1", o_err, o_busy);
    else n_pass++;
    // abandon the 32-word load via reset, then retry out of ERR
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_start(16'd33);
    do_start(16'd1);
    n_checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL ovf_clear: err=%b busy=%b want 0 1", o_err, o_busy);
    else n_pass++;
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    n_checks++;
    if (o_wr_en !== 1'b1 || o_wr_adr !== 32'h0 || o_wr_data !== 32'h00100513)
      $display("FAIL ovf_reload: en=%b adr=%h data=%h want 1 00000000 00100513",
               o_wr_en, o_wr_adr, o_wr_data);
    else n_pass++;
    @(negedge i_clk);
    n_checks++;
    if (o_done !== 1'b1 || o_err !== 1'b0)
      $display("FAIL ovf_reload_done: done=%b err=%b want 1 0", o_done, o_err);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    do_start(16'd2);
    send_byte(8'h93); send_byte(8'h02);
    do_start(16'd1);          // pulse while in RECV
    n_checks++;
    if (o_busy !== 1'b1 || o_byte_ready !== 1'b1)
      $display("FAIL ign_recv: busy=%b ready=%b want 1 1", o_busy, o_byte_ready);
    else n_pass++;
    send_byte(8'h40); send_byte(8'h00);
    n_checks++;
    if (o_wr_en !== 1'b1 || o_wr_adr !== 32'h0 || o_wr_data !== 32'h00400293)
      $display("FAIL ign_word0: en=%b adr=%h data=%h want 1 00000000 00400293",
               o_wr_en, o_wr_adr, o_wr_data);
    else n_pass++;
    do_start(16'd1);          // pulse while in WRITE
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0)
      $display("FAIL ign_write: busy=%b done=%b want 1 0", o_busy, o_done);
    else n_pass++;
    send_byte(8'h83); send_byte(8'ha3); send_byte(8'h42); send_byte(8'h00);
    n_checks++;
    if (o_wr_en !== 1'b1 || o_wr_adr !== 32'h4 || o_wr_data !== 32'h0042a383)
      $display("FAIL ign_word1: en=%b adr=%h data=%h want 1 00000004 0042a383",
               o_wr_en, o_wr_adr, o_wr_data);
    else n_pass++;
    @(negedge i_clk);
    n_checks++;
    if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1)
      $display("FAIL ign_done: done=%b cpu_rst_n=%b want 1 1", o_done, o_cpu_rst_n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_midload_reset();
    test_gaps();
    test_len_zero();
    test_overflow();
    test_start_ignored();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
